// File: rtl/vga_pkg.sv
// Timing constants and shared types for the 1440x900 raster and the snake display.
package vga_pkg;

    localparam int CNT_W    = 11;
    localparam int COLOUR_W = 4;

    localparam int H_ACTIVE = 1440;
    localparam int H_FP     = 80;
    localparam int H_SYNC   = 152;
    localparam int H_BP     = 232;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 900;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 3;
    localparam int V_BP     = 28;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic HS_POL = 1'b0;
    localparam logic VS_POL = 1'b1;

    localparam int PIPE_DLY = 1;

    // Playfield border shared with the draw controller.
    localparam int BORDER_LO   = 16;
    localparam int BORDER_HI_X = 1424;
    localparam int BORDER_HI_Y = 880;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } ctrl_t;

    function automatic logic in_window(input logic [CNT_W-1:0] value,
                                       input int lo, input int hi);
        return (value >= CNT_W'(lo)) && (value < CNT_W'(hi));
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth register delay line with an asynchronous active-low reset to RST_VAL.
module sig_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_out.sv
// Raster counters, sync/blank decode and the pin output register, aligned to the draw controller latency.
module vga_timing_out
    import vga_pkg::*;
#(
    parameter int   H_ACT     = H_ACTIVE,
    parameter int   H_FRONT   = H_FP,
    parameter int   H_SW      = H_SYNC,
    parameter int   H_BACK    = H_BP,
    parameter int   V_ACT     = V_ACTIVE,
    parameter int   V_FRONT   = V_FP,
    parameter int   V_SW      = V_SYNC,
    parameter int   V_BACK    = V_BP,
    parameter logic HSYNC_POL = HS_POL,
    parameter logic VSYNC_POL = VS_POL,
    parameter int   DRAW_DLY  = PIPE_DLY
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COLOUR_W-1:0] draw_r,
    input  logic [COLOUR_W-1:0] draw_g,
    input  logic [COLOUR_W-1:0] draw_b,
    output logic [CNT_W-1:0]    curr_x,
    output logic [CNT_W-1:0]    curr_y,
    output logic [COLOUR_W-1:0] vga_r,
    output logic [COLOUR_W-1:0] vga_g,
    output logic [COLOUR_W-1:0] vga_b,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                frame_tick,
    output logic                active
);

    localparam int H_TOT   = H_ACT + H_FRONT + H_SW + H_BACK;
    localparam int V_TOT   = V_ACT + V_FRONT + V_SW + V_BACK;
    localparam int HS_BEG  = H_ACT + H_FRONT;
    localparam int VS_BEG  = V_ACT + V_FRONT;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] V_PRE_BLANK = CNT_W'(V_ACT - 1);

    localparam ctrl_t CTRL_IDLE = '{hs: ~HSYNC_POL, vs: ~VSYNC_POL, act: 1'b0};

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             h_wrap;
    logic             v_wrap;
    ctrl_t            ctrl_raw;
    ctrl_t            ctrl_dly;

    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = (vcnt == V_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= h_wrap ? '0 : hcnt + 1'b1;
            if (h_wrap) begin
                vcnt <= v_wrap ? '0 : vcnt + 1'b1;
            end
        end
    end

    // Registered one cycle early so the pulse coincides with counters at (0, V_ACT).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= h_wrap && (vcnt == V_PRE_BLANK);
        end
    end

    assign curr_x = hcnt;
    assign curr_y = vcnt;

    always_comb begin
        ctrl_raw     = CTRL_IDLE;
        ctrl_raw.act = (hcnt < CNT_W'(H_ACT)) && (vcnt < CNT_W'(V_ACT));
        ctrl_raw.hs  = in_window(hcnt, HS_BEG, HS_BEG + H_SW) ? HSYNC_POL : ~HSYNC_POL;
        ctrl_raw.vs  = in_window(vcnt, VS_BEG, VS_BEG + V_SW) ? VSYNC_POL : ~VSYNC_POL;
    end

    sig_delay #(
        .WIDTH   ($bits(ctrl_t)),
        .DEPTH   (DRAW_DLY),
        .RST_VAL (CTRL_IDLE)
    ) u_ctrl_delay (
        .clk (clk),
        .rst (rst),
        .d   (ctrl_raw),
        .q   (ctrl_dly)
    );

    // Colour and control meet here so every pin changes on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= ~HSYNC_POL;
            vga_vs <= ~VSYNC_POL;
            active <= 1'b0;
        end else begin
            vga_r  <= ctrl_dly.act ? draw_r : '0;
            vga_g  <= ctrl_dly.act ? draw_g : '0;
            vga_b  <= ctrl_dly.act ? draw_b : '0;
            vga_hs <= ctrl_dly.hs;
            vga_vs <= ctrl_dly.vs;
            active <= ctrl_dly.act;
        end
    end

endmodule

// File: tb/tb_vga_timing_out.sv
// Scoreboard bench: a full-size instance over several lines and a tiny-raster instance over many frames.
module tb_vga_timing_out;

    localparam int A_DLY = 1;
    localparam int B_DLY = 2;
    localparam logic [14:0] RST_PINS = {12'h000, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic [3:0]  a_dr, a_dg, a_db, a_r, a_g, a_b;
    logic [10:0] a_x, a_y;
    logic        a_hs, a_vs, a_tick, a_act;
    logic [3:0]  b_dr, b_dg, b_db, b_r, b_g, b_b;
    logic [10:0] b_x, b_y;
    logic        b_hs, b_vs, b_tick, b_act;

    vga_timing_out u_dut_full (
        .clk(clk), .rst(rst), .draw_r(a_dr), .draw_g(a_dg), .draw_b(a_db),
        .curr_x(a_x), .curr_y(a_y), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .vga_hs(a_hs), .vga_vs(a_vs), .frame_tick(a_tick), .active(a_act)
    );

    vga_timing_out #(
        .H_ACT(8), .H_FRONT(2), .H_SW(2), .H_BACK(2),
        .V_ACT(4), .V_FRONT(1), .V_SW(1), .V_BACK(1), .DRAW_DLY(B_DLY)
    ) u_dut_small (
        .clk(clk), .rst(rst), .draw_r(b_dr), .draw_g(b_dg), .draw_b(b_db),
        .curr_x(b_x), .curr_y(b_y), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .vga_hs(b_hs), .vga_vs(b_vs), .frame_tick(b_tick), .active(b_act)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [11:0] pattern(input logic [10:0] x, input logic [10:0] y);
        return {x[3:0], y[3:0], x[7:4] ^ y[7:4]};
    endfunction

    // Expected {r,g,b,hs,vs,active} for one counter position.
    function automatic logic [14:0] expectPins(input int hc, input int vc,
            input int ha, input int hf, input int hsw, input int va, input int vf, input int vsw,
            input logic hpol, input logic vpol, input logic [11:0] colour);
        logic act, hs, vs;
        act = (hc < ha) && (vc < va);
        hs  = (hc >= ha + hf && hc < ha + hf + hsw) ? hpol : ~hpol;
        vs  = (vc >= va + vf && vc < va + vf + vsw) ? vpol : ~vpol;
        return {act ? colour : 12'h000, hs, vs, act};
    endfunction

    int          a_h, a_v, b_h, b_v;
    logic [14:0] a_exp[$], b_exp[$];
    logic [11:0] a_draw[$], b_draw[$];

    // Full-size raster: 1904 x 932, one-clock draw latency.
    always @(negedge clk) begin
        if (!rst) begin
            a_h = 0; a_v = 0;
            a_exp.delete(); a_draw.delete();
            for (int i = 0; i <= A_DLY; i++) a_exp.push_back(RST_PINS);
            {a_dr, a_dg, a_db} = 12'h000;
        end else begin
            checkOutput("full.curr_x", 32'(a_x), 32'(a_h));
            checkOutput("full.curr_y", 32'(a_y), 32'(a_v));
            checkOutput("full.frame_tick", 32'(a_tick), 32'(a_h == 0 && a_v == 900));
            a_exp.push_back(expectPins(a_h, a_v, 1440, 80, 152, 900, 1, 3, 1'b0, 1'b1,
                                       pattern(11'(a_h), 11'(a_v))));
            if (a_exp.size() == A_DLY + 2)
                checkOutput("full.pins", 32'({a_r, a_g, a_b, a_hs, a_vs, a_act}), 32'(a_exp.pop_front()));
            a_draw.push_back(pattern(a_x, a_y));
            if (a_draw.size() > A_DLY) {a_dr, a_dg, a_db} = a_draw.pop_front();
            a_h++;
            if (a_h == 1904) begin
                a_h = 0; a_v++;
                if (a_v == 932) a_v = 0;
            end
        end
    end

    // Tiny raster: 14 x 7, two-clock draw latency.
    always @(negedge clk) begin
        if (!rst) begin
            b_h = 0; b_v = 0;
            b_exp.delete(); b_draw.delete();
            for (int i = 0; i <= B_DLY; i++) b_exp.push_back(RST_PINS);
            {b_dr, b_dg, b_db} = 12'h000;
        end else begin
            checkOutput("small.curr_x", 32'(b_x), 32'(b_h));
            checkOutput("small.curr_y", 32'(b_y), 32'(b_v));
            checkOutput("small.frame_tick", 32'(b_tick), 32'(b_h == 0 && b_v == 4));
            b_exp.push_back(expectPins(b_h, b_v, 8, 2, 2, 4, 1, 1, 1'b0, 1'b1,
                                       pattern(11'(b_h), 11'(b_v))));
            if (b_exp.size() == B_DLY + 2)
                checkOutput("small.pins", 32'({b_r, b_g, b_b, b_hs, b_vs, b_act}), 32'(b_exp.pop_front()));
            b_draw.push_back(pattern(b_x, b_y));
            if (b_draw.size() > B_DLY) {b_dr, b_dg, b_db} = b_draw.pop_front();
            b_h++;
            if (b_h == 14) begin
                b_h = 0; b_v++;
                if (b_v == 7) b_v = 0;
            end
        end
    end

    task automatic applyStimulus();
        bit found;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.full.pos", 32'({a_x, a_y}), 32'h0);
        checkOutput("reset.full.pins", 32'({a_r, a_g, a_b, a_hs, a_vs, a_act, a_tick}), 32'({RST_PINS, 1'b0}));
        checkOutput("reset.small.pos", 32'({b_x, b_y}), 32'h0);
        checkOutput("reset.small.pins", 32'({b_r, b_g, b_b, b_hs, b_vs, b_act, b_tick}), 32'({RST_PINS, 1'b0}));
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (5000) @(posedge clk);

        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (a_x == 11'd800) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("wait.curr_x_800", 32'(found), 32'd1);

        // Assert mid-line between edges; outputs must clear before any clock edge.
        #2 rst = 1'b0;
        #1;
        checkOutput("midreset.full.pos", 32'({a_x, a_y}), 32'h0);
        checkOutput("midreset.full.pins", 32'({a_r, a_g, a_b, a_hs, a_vs, a_act, a_tick}), 32'({RST_PINS, 1'b0}));
        checkOutput("midreset.small.pos", 32'({b_x, b_y}), 32'h0);
        checkOutput("midreset.small.pins", 32'({b_r, b_g, b_b, b_hs, b_vs, b_act, b_tick}), 32'({RST_PINS, 1'b0}));
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (4500) @(posedge clk);
    endtask

    initial begin
        applyStimulus();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
